// File: rtl/sram_arb_pkg.sv
// Shared types and default widths for the SRAM arbiter slice.
package sram_arb_pkg;

    localparam int unsigned ADDR_W_DEF       = 16;
    localparam int unsigned DATA_W_DEF       = 16;
    localparam int unsigned LEN_W_DEF        = 8;
    localparam int unsigned STARVE_LIMIT_DEF = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dma_beat_ctr.sv
// Burst address incrementer plus beats-left down-counter.
//   load/load_addr/load_len : start a new burst (load wins over adv)
//   adv                     : one beat issued this cycle
//   cur_addr                : address of the next beat (wraps modulo 2^ADDR_W)
//   last                    : the next beat is the final one of the burst
module dma_beat_ctr
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [LEN_W-1:0]  load_len,
    input  logic              adv,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              last
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  left_q, left_d;

    // Next address / remaining-beat count
    always_comb begin
        addr_d = addr_q;
        left_d = left_q;
        if (load) begin
            addr_d = load_addr;
            left_d = load_len;
        end else if (adv) begin
            addr_d = addr_q + ADDR_W'(1);
            left_d = left_q - LEN_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            left_q <= '0;
        end else begin
            addr_q <= addr_d;
            left_q <= left_d;
        end
    end

    assign cur_addr = addr_q;
    assign last     = (left_q == '0);

endmodule

// File: rtl/sram_arbiter.sv
// Shares one asynchronous-read SRAM port between a never-stalled CPU
// (combinational pass-through, absolute priority) and a burst DMA that
// only uses cycles the CPU leaves idle.
//   cpu_*      : CPU data-memory strobes; cpu_rdata = sram_rdata
//   dma_req/wr/addr/len : burst command, sampled in IDLE only
//   dma_wdata/dma_wready: write beat data / consumed this edge
//   dma_rvalid/dma_rdata: registered read beat
//   dma_busy/dma_done/starve : burst status
//   sram_*     : board SRAM pins
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W       = ADDR_W_DEF,
    parameter int unsigned DATA_W       = DATA_W_DEF,
    parameter int unsigned LEN_W        = LEN_W_DEF,
    parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_wr,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [LEN_W-1:0]  dma_len,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_wready,
    output logic              dma_rvalid,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_busy,
    output logic              dma_done,
    output logic              starve,
    output logic [ADDR_W-1:0] sram_addr,
    output logic              sram_re,
    output logic              sram_we,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    arb_state_e        state_q, state_d;
    logic              wr_q, wr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              starve_q, starve_d;

    logic              cpu_act_c;
    logic              beat_c;
    logic              load_c;
    logic              last_c;
    logic [ADDR_W-1:0] cur_addr_c;

    assign cpu_act_c = cpu_re | cpu_we;
    // Reset gates the beat so an abandoned burst never touches the SRAM.
    assign beat_c    = (state_q == BURST) && !cpu_act_c && !rst;

    dma_beat_ctr #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_beat_ctr (
        .clk       (clk),
        .rst       (rst),
        .load      (load_c),
        .load_addr (dma_addr),
        .load_len  (dma_len),
        .adv       (beat_c),
        .cur_addr  (cur_addr_c),
        .last      (last_c)
    );

    // SRAM port mux: CPU first, then a DMA beat, otherwise quiet
    always_comb begin
        sram_addr  = '0;
        sram_re    = 1'b0;
        sram_we    = 1'b0;
        sram_wdata = '0;
        dma_wready = 1'b0;
        if (cpu_act_c) begin
            sram_addr  = cpu_addr;
            sram_we    = cpu_we;
            sram_re    = cpu_re & ~cpu_we;
            sram_wdata = cpu_wdata;
        end else if (beat_c) begin
            sram_addr = cur_addr_c;
            if (wr_q) begin
                sram_we    = 1'b1;
                sram_wdata = dma_wdata;
                dma_wready = 1'b1;
            end else begin
                sram_re = 1'b1;
            end
        end
    end

    assign cpu_rdata = sram_rdata;

    // Next state, starvation counter and registered status
    always_comb begin
        state_d = state_q;
        wr_d    = wr_q;
        load_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dma_req) begin
                    load_c  = 1'b1;
                    wr_d    = dma_wr;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (beat_c && last_c) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (state_q == BURST && !beat_c) begin
            cnt_d = (cnt_q >= CNT_W'(STARVE_LIMIT)) ? cnt_q : cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        rvalid_d = beat_c & ~wr_q;
        rdata_d  = rvalid_d ? sram_rdata : rdata_q;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == DONE);
        starve_d = (cnt_d >= CNT_W'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            wr_q     <= 1'b0;
            cnt_q    <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            starve_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_q     <= wr_d;
            cnt_q    <= cnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            starve_q <= starve_d;
        end
    end

    assign dma_rvalid = rvalid_q;
    assign dma_rdata  = rdata_q;
    assign dma_busy   = busy_q;
    assign dma_done   = done_q;
    assign starve     = starve_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter with a behavioural async-read SRAM.
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_re, cpu_we;
    logic        dma_req, dma_wr;
    logic [15:0] dma_addr, dma_wdata, dma_rdata;
    logic [7:0]  dma_len;
    logic        dma_wready, dma_rvalid, dma_busy, dma_done, starve;
    logic [15:0] sram_addr, sram_wdata, sram_rdata;
    logic        sram_re, sram_we;

    logic [15:0] mem [0:65535];
    logic [15:0] wptr;
    logic        wptr_clr;
    logic [15:0] exp_q [$];
    logic [15:0] exp_v;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    sram_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_addr   (cpu_addr),
        .cpu_re     (cpu_re),
        .cpu_we     (cpu_we),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .dma_req    (dma_req),
        .dma_wr     (dma_wr),
        .dma_addr   (dma_addr),
        .dma_len    (dma_len),
        .dma_wdata  (dma_wdata),
        .dma_wready (dma_wready),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .dma_busy   (dma_busy),
        .dma_done   (dma_done),
        .starve     (starve),
        .sram_addr  (sram_addr),
        .sram_re    (sram_re),
        .sram_we    (sram_we),
        .sram_wdata (sram_wdata),
        .sram_rdata (sram_rdata)
    );

    // SRAM model: async read, write at the edge
    assign sram_rdata = mem[sram_addr];
    always @(posedge clk) if (sram_we) mem[sram_addr] <= sram_wdata;

    // DMA write source: beat i carries 0x1111*(i+1)
    always @(posedge clk) begin
        if (wptr_clr)        wptr <= 16'd0;
        else if (dma_wready) wptr <= wptr + 16'd1;
    end
    assign dma_wdata = 16'(16'h1111 * (wptr + 16'd1));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Read-beat scoreboard
    always @(negedge clk) begin
        if (!rst && dma_rvalid) begin
            if (exp_q.size() == 0) begin
                check("rvalid_unexpected", 32'd1, 32'd0);
            end else begin
                exp_v = exp_q.pop_front();
                check("dma_rdata", 32'(dma_rdata), 32'(exp_v));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1);
    end

    task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
        @(posedge clk); #1;
        cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(posedge clk); #1;
        cpu_we = 1'b0;
    endtask

    // Runs one burst; cpu_k (1-based cycle after acceptance, 0 = none) gets a CPU read of 0x0050.
    task automatic run_burst(input logic wr, input logic [15:0] addr, input logic [7:0] len,
                             input int cpu_k, input string nm);
        int k, beat, k_done;
        k = 1; beat = 0; k_done = 0;
        @(posedge clk); #1;
        dma_req = 1'b1; dma_wr = wr; dma_addr = addr; dma_len = len; wptr_clr = 1'b1;
        @(negedge clk);
        check({nm, "_busy_accept"}, 32'(dma_busy), 32'd0);
        @(posedge clk); #1;
        dma_req = 1'b0; wptr_clr = 1'b0;
        while (k_done == 0 && k <= 600) begin
            if (k == cpu_k) begin cpu_re = 1'b1; cpu_addr = 16'h0050; end
            @(negedge clk);
            if (dma_done) begin
                k_done = k;
            end else begin
                check({nm, "_busy"}, 32'(dma_busy), 32'd1);
                if (k == cpu_k) begin
                    check({nm, "_cpu_addr"}, 32'(sram_addr), 32'h0050);
                    check({nm, "_cpu_noready"}, 32'(dma_wready), 32'd0);
                    check({nm, "_cpu_re"}, 32'(sram_re), 32'd1);
                    check({nm, "_cpu_rdata"}, 32'(cpu_rdata), 32'hBEEF);
                end else begin
                    check({nm, "_beat_addr"}, 32'(sram_addr), 32'(16'(addr + 16'(beat))));
                    if (wr) begin
                        check({nm, "_beat_we"}, 32'(sram_we & dma_wready), 32'd1);
                        check({nm, "_beat_wdata"}, 32'(sram_wdata), 32'(16'(16'h1111 * (beat + 1))));
                    end else begin
                        check({nm, "_beat_re"}, 32'(sram_re), 32'd1);
                    end
                    beat++;
                end
            end
            @(posedge clk); #1;
            cpu_re = 1'b0;
            k++;
        end
        check({nm, "_done_latency"}, 32'(k_done), 32'(int'(len) + 2 + (cpu_k != 0 ? 1 : 0)));
        check({nm, "_beats"}, 32'(beat), 32'(int'(len) + 1));
        @(negedge clk);
        check({nm, "_busy_after"}, 32'(dma_busy), 32'd0);
        check({nm, "_done_pulse"}, 32'(dma_done), 32'd0);
    endtask

    initial begin
        rst = 1'b1; cpu_addr = '0; cpu_re = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
        dma_req = 1'b0; dma_wr = 1'b0; dma_addr = '0; dma_len = '0; wptr_clr = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; wptr_clr = 1'b0;
        @(negedge clk);
        check("rst_busy",   32'(dma_busy),   32'd0);
        check("rst_done",   32'(dma_done),   32'd0);
        check("rst_rvalid", 32'(dma_rvalid), 32'd0);
        check("rst_rdata",  32'(dma_rdata),  32'd0);
        check("rst_starve", 32'(starve),     32'd0);
        check("rst_wready", 32'(dma_wready), 32'd0);
        check("rst_sram",   32'({sram_we, sram_re, sram_addr}), 32'd0);

        // Unblocked read burst
        cpu_write(16'h0050, 16'hBEEF);
        for (int i = 0; i < 4; i++) cpu_write(16'(16'h0100 + i), 16'(16'h00A0 + i));
        for (int i = 0; i < 4; i++) exp_q.push_back(16'(16'h00A0 + i));
        run_burst(1'b0, 16'h0100, 8'd3, 0, "rd");

        // Write burst with a CPU read on the 2nd beat cycle
        run_burst(1'b1, 16'h0200, 8'd3, 2, "wr");
        for (int i = 0; i < 4; i++)
            check("wr_mem", 32'(mem[16'(16'h0200 + i)]), 32'(16'(16'h1111 * (i + 1))));

        // Address wrap
        cpu_write(16'hFFFF, 16'hF0F0);
        cpu_write(16'h0000, 16'h0A0A);
        cpu_write(16'h0001, 16'h0B0B);
        exp_q.push_back(16'hF0F0); exp_q.push_back(16'h0A0A); exp_q.push_back(16'h0B0B);
        run_burst(1'b0, 16'hFFFF, 8'd2, 0, "wrap");

        // Starvation: CPU busy for 70 cycles of a 2-beat read burst
        cpu_write(16'h0300, 16'h00C0);
        cpu_write(16'h0301, 16'h00C1);
        exp_q.push_back(16'h00C0); exp_q.push_back(16'h00C1);
        @(posedge clk); #1;
        dma_req = 1'b1; dma_wr = 1'b0; dma_addr = 16'h0300; dma_len = 8'd1;
        @(posedge clk); #1;
        dma_req = 1'b0; cpu_re = 1'b1; cpu_addr = 16'h0010;
        for (int k = 1; k <= 70; k++) begin
            @(negedge clk);
            check("starve_blocked", 32'(starve), 32'(k >= 65));
            @(posedge clk); #1;
        end
        cpu_re = 1'b0;
        @(negedge clk);
        check("starve_first_beat", 32'(starve), 32'd1);
        check("starve_beat0_addr", 32'(sram_addr), 32'h0300);
        @(posedge clk); #1;
        @(negedge clk);
        check("starve_cleared", 32'(starve), 32'd0);
        check("starve_beat1_addr", 32'(sram_addr), 32'h0301);
        @(posedge clk); #1;
        @(negedge clk);
        check("starve_done", 32'(dma_done), 32'd1);

        // Simultaneous CPU read and write: write wins
        @(posedge clk); #1;
        cpu_re = 1'b1; cpu_we = 1'b1; cpu_addr = 16'h0060; cpu_wdata = 16'h5A5A;
        @(negedge clk);
        check("rw_we",    32'(sram_we),    32'd1);
        check("rw_re",    32'(sram_re),    32'd0);
        check("rw_addr",  32'(sram_addr),  32'h0060);
        check("rw_wdata", 32'(sram_wdata), 32'h5A5A);
        @(posedge clk); #1;
        cpu_re = 1'b0; cpu_we = 1'b0;
        check("rw_mem", 32'(mem[16'h0060]), 32'h5A5A);

        // Reset after two beats of an 8-beat write burst
        cpu_write(16'h0402, 16'h0000);
        cpu_write(16'h0403, 16'h0000);
        @(posedge clk); #1;
        dma_req = 1'b1; dma_wr = 1'b1; dma_addr = 16'h0400; dma_len = 8'd7; wptr_clr = 1'b1;
        @(posedge clk); #1;
        dma_req = 1'b0; wptr_clr = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("rstmid_we",     32'(sram_we),    32'd0);
        check("rstmid_wready", 32'(dma_wready), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rstmid_busy", 32'(dma_busy), 32'd0);
        for (int i = 0; i < 12; i++) begin
            check("rstmid_quiet", 32'({dma_done, dma_busy, sram_we}), 32'd0);
            @(negedge clk);
        end
        check("rstmid_mem0", 32'(mem[16'h0400]), 32'h1111);
        check("rstmid_mem1", 32'(mem[16'h0401]), 32'h2222);
        check("rstmid_mem2", 32'(mem[16'h0402]), 32'h0000);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
